// File: rtl/ads1220_pkg.sv
// Shared command bytes, FSM state encodings and helpers for the ADS1220 sequencer.
package ads1220_pkg;

    localparam logic [7:0] CMD_RESET = 8'h06;
    localparam logic [7:0] CMD_START = 8'h08;
    localparam logic [7:0] CMD_WREG  = 8'h40;

    localparam int NUM_CFG_REGS = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_CMD,
        S_RST_WAIT,
        S_WREG0,
        S_WREG1,
        S_WREG2,
        S_WREG3,
        S_START_CMD,
        S_WAIT_DRDY,
        S_RD_HI,
        S_RD_LO,
        S_OUT
    } state_e;

    // Sub-steps of one SPI word inside a transaction.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ARM,
        PH_WAIT,
        PH_GAP
    } phase_e;

    // Single-register WREG word: command with register index in bits [3:2], then the data byte.
    function automatic logic [15:0] wreg_word(input logic [1:0] idx, input logic [31:0] cfg);
        logic [31:0] shifted;
        shifted = cfg >> {idx, 3'b000};
        return {CMD_WREG | {4'b0000, idx, 2'b00}, shifted[7:0]};
    endfunction

endpackage

// File: rtl/ads_drdy_sync.sv
// Brings the asynchronous DRDY line into the clk domain and flags its falling edge.
module ads_drdy_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic drdy_n_i,
    output logic drdy_fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchroniser plus one history flop for edge detection; idles high like the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= drdy_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign drdy_fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ads1220_ctrl.sv
// ADS1220 sequencer: reset/configure the ADC over the SPI engine, then read a sample on every DRDY.
module ads1220_ctrl
    import ads1220_pkg::*;
#(
    parameter int RST_WAIT     = 3000,
    parameter int DRDY_TIMEOUT = 2000000,
    parameter int CS_GAP       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        reconfig_i,
    input  logic [31:0] cfg_i,
    input  logic        drdy_n_i,
    output logic        cs_n_o,
    output logic        spi_go_o,
    output logic [15:0] spi_wrdat_o,
    input  logic [15:0] spi_rddat_i,
    input  logic        spi_ok_i,
    output logic [23:0] data_o,
    output logic        data_valid_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

    localparam logic [31:0] RST_WAIT_L = 32'(RST_WAIT);
    localparam logic [31:0] TIMEOUT_L  = 32'(DRDY_TIMEOUT);
    localparam logic [31:0] CS_GAP_L   = 32'(CS_GAP);
    localparam bit          TIMEOUT_EN = (DRDY_TIMEOUT != 0);

    state_e      state_q;
    phase_e      phase_q;
    logic [31:0] cnt_q;
    logic [31:0] cfg_q;
    logic        cs_n_q;
    logic        go_q;
    logic [15:0] wrdat_q;
    logic [15:0] hi_q;
    logic [7:0]  lo_q;
    logic [23:0] data_q;
    logic        valid_q;
    logic        terr_q;
    logic        reconf_pend_q;

    logic        drdy_fall;
    logic [15:0] xfer_word_d;
    state_e      after_state_d;
    logic        last_word_d;
    logic        reconf_now_d;

    ads_drdy_sync u_drdy_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .drdy_n_i   (drdy_n_i),
        .drdy_fall_o(drdy_fall)
    );

    // Per-state word to shift, the state that follows the transaction, and whether this word ends it.
    always_comb begin
        xfer_word_d   = 16'h0000;
        after_state_d = S_IDLE;
        last_word_d   = 1'b1;
        reconf_now_d  = reconf_pend_q | reconfig_i;
        case (state_q)
            S_RST_CMD: begin
                xfer_word_d   = {CMD_RESET, CMD_RESET};
                after_state_d = S_RST_WAIT;
            end
            S_WREG0: begin
                xfer_word_d   = wreg_word(2'd0, cfg_q);
                after_state_d = S_WREG1;
            end
            S_WREG1: begin
                xfer_word_d   = wreg_word(2'd1, cfg_q);
                after_state_d = S_WREG2;
            end
            S_WREG2: begin
                xfer_word_d   = wreg_word(2'd2, cfg_q);
                after_state_d = S_WREG3;
            end
            S_WREG3: begin
                xfer_word_d   = wreg_word(2'(NUM_CFG_REGS - 1), cfg_q);
                after_state_d = S_START_CMD;
            end
            S_START_CMD: begin
                xfer_word_d   = {CMD_START, CMD_START};
                after_state_d = S_WAIT_DRDY;
            end
            S_RD_HI: begin
                last_word_d   = 1'b0;
                after_state_d = S_RD_LO;
            end
            S_RD_LO: begin
                after_state_d = S_OUT;
            end
            default: ;
        endcase
    end

    // Main sequencer: word handshake, cs_n framing, waits/timeout and sample assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_SETUP;
            cnt_q         <= '0;
            cfg_q         <= '0;
            cs_n_q        <= 1'b1;
            go_q          <= 1'b0;
            wrdat_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            terr_q        <= 1'b0;
            reconf_pend_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (reconfig_i) reconf_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q       <= S_RST_CMD;
                        phase_q       <= PH_SETUP;
                        cfg_q         <= cfg_i;
                        terr_q        <= 1'b0;
                        reconf_pend_q <= 1'b0;
                        cnt_q         <= '0;
                    end
                end
                S_RST_WAIT: begin
                    if (cnt_q + 32'd1 >= RST_WAIT_L) begin
                        state_q <= S_WREG0;
                        phase_q <= PH_SETUP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_WAIT_DRDY: begin
                    if (reconf_now_d) begin
                        state_q       <= S_RST_CMD;
                        phase_q       <= PH_SETUP;
                        cfg_q         <= cfg_i;
                        reconf_pend_q <= 1'b0;
                        cnt_q         <= '0;
                    end else if (drdy_fall) begin
                        state_q <= S_RD_HI;
                        phase_q <= PH_SETUP;
                        cnt_q   <= '0;
                    end else if (TIMEOUT_EN && (cnt_q + 32'd1 >= TIMEOUT_L)) begin
                        terr_q  <= 1'b1;
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_OUT: begin
                    data_q  <= {hi_q, lo_q};
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                    phase_q <= PH_SETUP;
                    if (reconf_now_d) begin
                        state_q       <= S_RST_CMD;
                        cfg_q         <= cfg_i;
                        reconf_pend_q <= 1'b0;
                    end else if (drdy_fall) begin
                        state_q <= S_RD_HI;
                    end else begin
                        state_q <= S_WAIT_DRDY;
                    end
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            cs_n_q  <= 1'b0;
                            wrdat_q <= xfer_word_d;
                            phase_q <= PH_ARM;
                        end
                        PH_ARM: begin
                            if (!spi_ok_i) begin
                                go_q    <= 1'b1;
                                phase_q <= PH_WAIT;
                            end
                        end
                        PH_WAIT: begin
                            if (spi_ok_i) begin
                                go_q <= 1'b0;
                                if (state_q == S_RD_HI) hi_q <= spi_rddat_i;
                                if (state_q == S_RD_LO) lo_q <= spi_rddat_i[15:8];
                                if (last_word_d) begin
                                    cs_n_q  <= 1'b1;
                                    phase_q <= PH_GAP;
                                    cnt_q   <= '0;
                                end else begin
                                    state_q <= after_state_d;
                                    wrdat_q <= 16'h0000;
                                    phase_q <= PH_ARM;
                                end
                            end
                        end
                        PH_GAP: begin
                            if (cnt_q + 32'd1 >= CS_GAP_L) begin
                                cnt_q   <= '0;
                                phase_q <= PH_SETUP;
                                if (after_state_d != S_WAIT_DRDY) begin
                                    state_q <= after_state_d;
                                end else if (reconf_now_d) begin
                                    state_q       <= S_RST_CMD;
                                    cfg_q         <= cfg_i;
                                    reconf_pend_q <= 1'b0;
                                end else if (drdy_fall) begin
                                    state_q <= S_RD_HI;
                                end else begin
                                    state_q <= S_WAIT_DRDY;
                                end
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: phase_q <= PH_SETUP;
                    endcase
                end
            endcase
        end
    end

    assign cs_n_o        = cs_n_q;
    assign spi_go_o      = go_q;
    assign spi_wrdat_o   = wrdat_q;
    assign data_o        = data_q;
    assign data_valid_o  = valid_q;
    assign busy_o        = (state_q != S_IDLE);
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_ads1220_ctrl.sv
// Self-checking bench for ads1220_ctrl with an SPI engine model, an ADC reply model and a scoreboard.
module tb_ads1220_ctrl;

    localparam int RST_WAIT_P = 20;
    localparam int TIMEOUT_P  = 100;
    localparam int CS_GAP_P   = 2;
    localparam int ENG_LAT    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        reconfig_i = 1'b0;
    logic [31:0] cfg_i = 32'h0;
    logic        drdy_n_i = 1'b1;
    logic        cs_n_o;
    logic        spi_go_o;
    logic [15:0] spi_wrdat_o;
    logic [15:0] spi_rddat_i;
    logic        spi_ok_i;
    logic [23:0] data_o;
    logic        data_valid_o;
    logic        busy_o;
    logic        timeout_err_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [15:0] exp_words[$];
    logic [15:0] obs_words[$];
    int          obs_word_cyc[$];
    int          win_sizes[$];
    logic [23:0] exp_data[$];
    logic [23:0] obs_data[$];
    int          obs_data_cyc[$];
    logic [15:0] adc_reply[$];

    int   words_in_win = 0;
    int   valid_cnt = 0;
    int   last_valid_cyc = 0;
    int   go_rise_ok_viol = 0;
    int   go_no_cs_viol = 0;
    int   hold_ok = 0;
    int   hold_cnt;
    int   eng_cnt;
    logic go_prev = 1'b0;
    logic ok_prev = 1'b0;
    logic cs_prev = 1'b1;

    ads1220_ctrl #(
        .RST_WAIT    (RST_WAIT_P),
        .DRDY_TIMEOUT(TIMEOUT_P),
        .CS_GAP      (CS_GAP_P)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .reconfig_i   (reconfig_i),
        .cfg_i        (cfg_i),
        .drdy_n_i     (drdy_n_i),
        .cs_n_o       (cs_n_o),
        .spi_go_o     (spi_go_o),
        .spi_wrdat_o  (spi_wrdat_o),
        .spi_rddat_i  (spi_rddat_i),
        .spi_ok_i     (spi_ok_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .busy_o       (busy_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    // SPI engine model: ok after a fixed latency, held high until go falls plus hold_ok extra cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_ok_i    <= 1'b0;
            spi_rddat_i <= 16'h0;
            eng_cnt     <= 0;
            hold_cnt    <= 0;
        end else if (spi_go_o && !spi_ok_i) begin
            if (eng_cnt == ENG_LAT) begin
                spi_ok_i <= 1'b1;
                eng_cnt  <= 0;
                if (spi_wrdat_o == 16'h0000 && adc_reply.size() > 0) spi_rddat_i <= adc_reply.pop_front();
                else spi_rddat_i <= 16'h0000;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end else if (!spi_go_o && spi_ok_i) begin
            if (hold_cnt >= hold_ok) begin
                spi_ok_i <= 1'b0;
                hold_cnt <= 0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
    end

    // Bus monitor: collects completed words, cs_n windows, samples and handshake violations.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (spi_go_o && !go_prev && spi_ok_i) go_rise_ok_viol++;
        if (spi_go_o && cs_n_o) go_no_cs_viol++;
        if (spi_ok_i && !ok_prev && spi_go_o) begin
            obs_words.push_back(spi_wrdat_o);
            obs_word_cyc.push_back(cyc);
            words_in_win++;
        end
        if (cs_n_o && !cs_prev) begin
            win_sizes.push_back(words_in_win);
            words_in_win = 0;
        end
        if (data_valid_o) begin
            obs_data.push_back(data_o);
            obs_data_cyc.push_back(cyc);
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        go_prev = spi_go_o;
        ok_prev = spi_ok_i;
        cs_prev = cs_n_o;
    end

    task automatic flush_sb();
        exp_words.delete();
        obs_words.delete();
        obs_word_cyc.delete();
        win_sizes.delete();
        exp_data.delete();
        obs_data.delete();
        obs_data_cyc.delete();
        adc_reply.delete();
        words_in_win = 0;
    endtask

    task automatic wait_words(input int n, output bit ok);
        for (int i = 0; i < 3000 && obs_words.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (obs_words.size() >= n);
    endtask

    task automatic wait_data(input int n, output bit ok);
        for (int i = 0; i < 300 && obs_data.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic wait_wins(input int n, output bit ok);
        for (int i = 0; i < 300 && win_sizes.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (win_sizes.size() >= n);
    endtask

    task automatic pulse_start(input logic [31:0] cfg);
        @(negedge clk);
        cfg_i   = cfg;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
    endtask

    // Queue the ADC reply and expected sample, then produce a DRDY low pulse.
    task automatic adc_sample(input logic [23:0] s);
        adc_reply.push_back(s[23:8]);
        adc_reply.push_back({s[7:0], 8'hAA});
        exp_data.push_back(s);
        @(negedge clk);
        drdy_n_i = 1'b0;
        repeat (4) @(negedge clk);
        drdy_n_i = 1'b1;
    endtask

    task automatic push_init_words(input logic [31:0] cfg);
        exp_words.push_back(16'h0606);
        exp_words.push_back({8'h40, cfg[7:0]});
        exp_words.push_back({8'h44, cfg[15:8]});
        exp_words.push_back({8'h48, cfg[23:16]});
        exp_words.push_back({8'h4C, cfg[31:24]});
        exp_words.push_back(16'h0808);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (cs_n_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cs_n: got %b, required 1", cs_n_o); end
        tests_run++; if (spi_go_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_go: got %b, required 0", spi_go_o); end
        tests_run++; if (spi_wrdat_o !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_wrdat: got %h, required 0000", spi_wrdat_o); end
        tests_run++; if (data_o !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h, required 000000", data_o); end
        tests_run++; if (data_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b, required 0", data_valid_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, required 0", busy_o); end
        tests_run++; if (timeout_err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_terr: got %b, required 0", timeout_err_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy: got %b, required 0", busy_o); end
    endtask

    task automatic test_init();
        bit ok;
        int gap;
        logic [15:0] e, o;
        flush_sb();
        push_init_words(32'h0004_0021);
        pulse_start(32'h0004_0021);
        wait_words(6, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL init_count: got %0d words, required 6", obs_words.size()); end
        if (obs_word_cyc.size() >= 2) begin
            gap = obs_word_cyc[1] - obs_word_cyc[0];
            tests_run++; if (gap < RST_WAIT_P) begin tests_failed++; $display("[TB] FAIL init_rst_wait: got %0d cycles, required >= %0d", gap, RST_WAIT_P); end
        end
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            e = exp_words.pop_front();
            o = obs_words.pop_front();
            void'(obs_word_cyc.pop_front());
            tests_run++; if (o !== e) begin tests_failed++; $display("[TB] FAIL init_word: got %h, required %h", o, e); end
        end
        wait_wins(6, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL init_windows: got %0d windows, required 6", win_sizes.size()); end
        while (win_sizes.size() > 0) begin
            o = 16'(win_sizes.pop_front());
            tests_run++; if (o !== 16'd1) begin tests_failed++; $display("[TB] FAIL init_window_size: got %0d words, required 1", o); end
        end
    endtask

    task automatic test_read();
        bit ok;
        int v0;
        logic [23:0] d, ed;
        logic [15:0] e, o;
        flush_sb();
        v0 = valid_cnt;
        exp_words.push_back(16'h0000);
        exp_words.push_back(16'h0000);
        adc_sample(24'h7FFF12);
        wait_data(1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL read_wait: got no data_valid, required 1"); end
        if (ok) begin
            d = obs_data.pop_front();
            ed = exp_data.pop_front();
            tests_run++; if (d !== ed) begin tests_failed++; $display("[TB] FAIL read_data: got %h, required %h", d, ed); end
        end
        repeat (10) @(negedge clk);
        #1;
        tests_run++; if (valid_cnt - v0 != 1) begin tests_failed++; $display("[TB] FAIL read_valid_pulses: got %0d, required 1", valid_cnt - v0); end
        wait_wins(1, ok);
        tests_run++; if (!ok || win_sizes[0] != 2) begin tests_failed++; $display("[TB] FAIL read_window: got %0d words, required 2", ok ? win_sizes[0] : -1); end
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            e = exp_words.pop_front();
            o = obs_words.pop_front();
            tests_run++; if (o !== e) begin tests_failed++; $display("[TB] FAIL read_word: got %h, required %h", o, e); end
        end
    endtask

    task automatic test_negative();
        bit ok;
        logic [23:0] d, ed;
        flush_sb();
        adc_sample(24'h800001);
        wait_data(1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL neg_wait: got no data_valid, required 1"); end
        if (ok) begin
            d = obs_data.pop_front();
            ed = exp_data.pop_front();
            tests_run++; if (d !== ed) begin tests_failed++; $display("[TB] FAIL neg_data: got %h, required %h", d, ed); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int v0;
        logic [23:0] d, ed;
        logic [23:0] samples[3];
        flush_sb();
        samples[0] = 24'hFFFFFF;
        samples[1] = 24'h000001;
        samples[2] = 24'h5A3C96;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            adc_sample(samples[i]);
            wait_data(i + 1, ok);
        end
        repeat (5) @(negedge clk);
        #1;
        tests_run++; if (valid_cnt - v0 != 3) begin tests_failed++; $display("[TB] FAIL b2b_valid_pulses: got %0d, required 3", valid_cnt - v0); end
        while (exp_data.size() > 0) begin
            ed = exp_data.pop_front();
            d = (obs_data.size() > 0) ? obs_data.pop_front() : 24'hxxxxxx;
            tests_run++; if (d !== ed) begin tests_failed++; $display("[TB] FAIL b2b_data: got %h, required %h", d, ed); end
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int r0, c0;
        logic [23:0] d, ed;
        flush_sb();
        r0 = go_rise_ok_viol;
        c0 = go_no_cs_viol;
        hold_ok = 3;
        adc_sample(24'h13579B);
        wait_data(1, ok);
        hold_ok = 0;
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL hs_wait: got no data_valid, required 1"); end
        if (ok) begin
            d = obs_data.pop_front();
            ed = exp_data.pop_front();
            tests_run++; if (d !== ed) begin tests_failed++; $display("[TB] FAIL hs_data: got %h, required %h", d, ed); end
        end
        tests_run++; if (go_rise_ok_viol != r0) begin tests_failed++; $display("[TB] FAIL hs_go_while_ok: got %0d rises, required 0", go_rise_ok_viol - r0); end
        tests_run++; if (go_no_cs_viol != c0) begin tests_failed++; $display("[TB] FAIL hs_go_without_cs: got %0d cycles, required 0", go_no_cs_viol - c0); end
    endtask

    task automatic test_reconfig();
        bit ok;
        int rst_word_cyc;
        logic [23:0] d, ed;
        logic [15:0] e, o;
        flush_sb();
        exp_words.push_back(16'h0000);
        exp_words.push_back(16'h0000);
        push_init_words(32'hA55A_1234);
        adc_reply.push_back(16'h2468);
        adc_reply.push_back(16'hACAA);
        exp_data.push_back(24'h2468AC);
        @(negedge clk);
        cfg_i = 32'hA55A_1234;
        drdy_n_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = spi_go_o && !cs_n_o && (spi_wrdat_o == 16'h0000);
        end
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL reconf_rd_hi: got no read word, required one"); end
        reconfig_i = 1'b1;
        @(negedge clk);
        reconfig_i = 1'b0;
        drdy_n_i = 1'b1;
        wait_words(8, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL reconf_count: got %0d words, required 8", obs_words.size()); end
        wait_data(1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL reconf_valid: got no data_valid, required 1"); end
        if (ok && obs_word_cyc.size() >= 3) begin
            rst_word_cyc = obs_word_cyc[2];
            tests_run++; if (obs_data_cyc[0] >= rst_word_cyc) begin tests_failed++; $display("[TB] FAIL reconf_order: got valid at %0d, required before 0606 at %0d", obs_data_cyc[0], rst_word_cyc); end
            d = obs_data.pop_front();
            ed = exp_data.pop_front();
            tests_run++; if (d !== ed) begin tests_failed++; $display("[TB] FAIL reconf_data: got %h, required %h", d, ed); end
        end
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            e = exp_words.pop_front();
            o = obs_words.pop_front();
            tests_run++; if (o !== e) begin tests_failed++; $display("[TB] FAIL reconf_word: got %h, required %h", o, e); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [15:0] e, o;
        flush_sb();
        adc_sample(24'h000042);
        wait_data(1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL to_sample: got no data_valid, required 1"); end
        while (cyc < last_valid_cyc + TIMEOUT_P - 1) begin
            @(negedge clk);
            #1;
        end
        tests_run++; if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_early: got terr=%b busy=%b, required terr=0 busy=1", timeout_err_o, busy_o); end
        @(negedge clk);
        #1;
        tests_run++; if (timeout_err_o !== 1'b1 || busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_expire: got terr=%b busy=%b, required terr=1 busy=0", timeout_err_o, busy_o); end
        flush_sb();
        push_init_words(32'h0004_0021);
        pulse_start(32'h0004_0021);
        tests_run++; if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_restart: got terr=%b busy=%b, required terr=0 busy=1", timeout_err_o, busy_o); end
        wait_words(6, ok);
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            e = exp_words.pop_front();
            o = obs_words.pop_front();
            tests_run++; if (o !== e) begin tests_failed++; $display("[TB] FAIL to_reinit_word: got %h, required %h", o, e); end
        end
        for (int i = 0; i < 400 && busy_o; i++) begin
            @(negedge clk);
            #1;
        end
        tests_run++; if (busy_o !== 1'b0 || timeout_err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_second: got terr=%b busy=%b, required terr=1 busy=0", timeout_err_o, busy_o); end
    endtask

    task automatic test_reset_midxfer();
        bit ok;
        logic [15:0] e, o;
        flush_sb();
        pulse_start(32'h1122_3344);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = spi_go_o && (spi_wrdat_o == 16'h4822);
        end
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rst_reach_wreg2: got no WREG2 word, required 4822"); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (cs_n_o !== 1'b1 || spi_go_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_async_bus: got cs_n=%b go=%b, required cs_n=1 go=0", cs_n_o, spi_go_o); end
        tests_run++; if (busy_o !== 1'b0 || data_o !== 24'h0 || spi_wrdat_o !== 16'h0) begin tests_failed++; $display("[TB] FAIL rst_async_regs: got busy=%b data=%h wrdat=%h, required 0", busy_o, data_o, spi_wrdat_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        flush_sb();
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_stays_idle: got busy=%b, required 0", busy_o); end
        push_init_words(32'h1122_3344);
        pulse_start(32'h1122_3344);
        wait_words(6, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rst_reinit_count: got %0d words, required 6", obs_words.size()); end
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            e = exp_words.pop_front();
            o = obs_words.pop_front();
            tests_run++; if (o !== e) begin tests_failed++; $display("[TB] FAIL rst_reinit_word: got %h, required %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read();
        test_negative();
        test_back_to_back();
        test_handshake();
        test_reconfig();
        test_timeout();
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ads1220_ctrl.md
Name: ads1220_ctrl

Overview:
- Sequencer for the ADS1220 24-bit ADC that drives the team's 16-bit SPI shift engine through its go/wrdat/rddat/ok handshake.
- After a start request it issues RESET, writes the four configuration registers, then issues START/SYNC.
- It then services every DRDY falling edge with a 32-clock continuous-mode read, presenting 24-bit signed samples with a one-cycle valid strobe.
- It sits between the SPI engine and the sample consumer (filter/FIFO); it owns chip select and ADC bring-up.

Parameters:
- RST_WAIT, 3000: clk cycles to wait after the RESET command before the first WREG (covers ≥50 µs device reset time).
- DRDY_TIMEOUT, 2000000: clk cycles allowed in WAIT_DRDY before timeout_err is set; 0 disables the timeout.
- CS_GAP, 2: minimum clk cycles cs_n stays high between transactions.

Ports:
- clk, in, 1: system clock; also the SPI engine clock.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: pulse; begins the init sequence from IDLE. Ignored while busy.
- reconfig, in, 1: pulse; rerun the full init from the next transaction boundary.
- cfg, in, 32: {reg3, reg2, reg1, reg0}; sampled into a register when init begins.
- drdy_n, in, 1: ADC data-ready, asynchronous, active-low.
- cs_n, out, 1: ADC chip select, active-low.
- spi_go, out, 1: engine go; held high until spi_ok is seen.
- spi_wrdat, out, 16: word to shift, MSB first.
- spi_rddat, in, 16: word received.
- spi_ok, in, 1: engine done; remains high until spi_go falls.
- data, out, 24: latest sample, two's complement.
- data_valid, out, 1: one-cycle strobe, asserted when data updates.
- busy, out, 1: high in every state except IDLE.
- timeout_err, out, 1: sticky; cleared by start or reset.

Behaviour:
- Reset values: cs_n=1, spi_go=0, spi_wrdat=0, data=0, data_valid=0, busy=0, timeout_err=0; state=IDLE.
- drdy_n passes through a 2-FF synchroniser. drdy_fall is a 1-cycle pulse on a synchronised 1→0 transition.
- Word transfer (XFER sub-sequence):
  - Set spi_wrdat.
  - Next cycle, assert spi_go.
  - Hold spi_go until spi_ok=1; capture spi_rddat in that same cycle.
  - Deassert spi_go for at least one cycle before the next word, so the engine counter returns to 0.
  - Never assert spi_go while spi_ok is still high.
- Transaction framing:
  - cs_n falls one cycle before the first spi_go.
  - cs_n rises in the cycle after the last word's spi_ok.
  - cs_n then stays high for ≥CS_GAP cycles.
- States and words:
  - IDLE: wait for start.
  - RST_CMD: one word, 16'h0606.
  - RST_WAIT: count RST_WAIT cycles.
  - WREG0..WREG3: one transaction each, word {8'h40|(n<<2), cfg byte n}.
  - START_CMD: word 16'h0808.
  - WAIT_DRDY: wait for drdy_fall.
  - RD_HI then RD_LO: one transaction of two words, both 16'h0000, cs_n held low across both.
  - OUT: data <= {hi[15:0], lo[15:8]}, data_valid=1 for one cycle, then back to WAIT_DRDY.
- A drdy_fall that occurs outside WAIT_DRDY is dropped and not queued.
- A drdy_fall in the same cycle as entry to WAIT_DRDY is honoured.
- reconfig:
  - Latched when it arrives.
  - Acted on only when entering WAIT_DRDY, or immediately if already waiting; never splits a transaction.
  - Jumps to RST_CMD and re-samples cfg.
- Timeout (DRDY_TIMEOUT≠0): the counter runs in WAIT_DRDY and clears on drdy_fall. On expiry, set timeout_err and return to IDLE with busy=0.
- start while busy is ignored; start from IDLE clears timeout_err.
- Asynchronous reset mid-transfer: all outputs return to reset values at once, cs_n=1 immediately. The next start performs the full init.

Decomposition:
- Package ads1220_pkg:
  - command constants: CMD_RESET=8'h06, CMD_START=8'h08, CMD_WREG=8'h40;
  - state enum;
  - localparam for the number of config registers (4).
- Sub-module ads_drdy_sync: 2-FF synchroniser plus falling-edge pulse.
- Everything else is one FSM with a shared wait/timeout counter.

Test Plan:
- Init: cfg=32'h0004_0021, start pulse → word sequence 0606, 4021, 4400, 4804, 4C00, 0808, with each word in its own cs_n-low window; ≥RST_WAIT cycles between the 0606 and 4021 transactions.
- Read: ADC model returns 24'h7FFF12 + 8'hAA after a drdy_n fall → data=24'h7FFF12, one data_valid pulse; cs_n low for exactly 2 words.
- Negative sample: model returns 24'h800001 → data=24'h800001. Three back-to-back DRDY events → three data_valid pulses.
- Handshake: engine model holds ok high → spi_go drops before the next word; no spi_go rising edge while ok=1.
- Timeout: DRDY_TIMEOUT=100, drdy_n held high → timeout_err=1 and busy=0 after 100 cycles; next start clears timeout_err.
- Reconfig and reset: reconfig pulsed during RD_HI → read completes with data_valid, then 0606 is issued. rst_n asserted mid-WREG2 → cs_n=1 and spi_go=0 at once.
